// File: rtl/gnn_layer_seq.sv
// Time-multiplexed GNN layer: adjacency-masked aggregation, serial F_IN->F_OUT MAC, optional ReLU.
// Build option: define GNN_RELU_EN to clamp negative outputs to zero.
module gnn_layer_seq #(
    parameter int N     = 4,
    parameter int F_IN  = 4,
    parameter int F_OUT = 2,
    parameter int IN_W  = 5,
    parameter int W_W   = 5,
    parameter int AGG_W = IN_W + $clog2(N),
    parameter int OUT_W = AGG_W + W_W + $clog2(F_IN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*F_IN*IN_W-1:0]       x_flat,
    input  logic [F_IN*F_OUT*W_W-1:0]    w_flat,
    input  logic [N*N-1:0]               adj,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*F_OUT*OUT_W-1:0]     y_flat
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (F_IN > 1) ? $clog2(F_IN) : 1;
    localparam int OW = (F_OUT > 1) ? $clog2(F_OUT) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [FW-1:0] I_LAST = FW'(F_IN - 1);
    localparam logic [OW-1:0] O_LAST = OW'(F_OUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AGGR = 2'd1;
    localparam logic [1:0] S_MAC  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]               state;
    logic [NW-1:0]            n_cnt;
    logic [OW-1:0]            o_cnt;
    logic [FW-1:0]            i_cnt;
    logic signed [OUT_W-1:0]  acc;
    logic signed [OUT_W-1:0]  y_r   [N][F_OUT];

    logic signed [IN_W-1:0]   x_r   [N][F_IN];
    logic signed [W_W-1:0]    w_r   [F_IN][F_OUT];
    logic [N*N-1:0]           adj_r;
    logic signed [AGG_W-1:0]  a_r   [N][F_IN];
    logic signed [AGG_W-1:0]  agg   [N][F_IN];

    logic signed [OUT_W-1:0]  prod;
    logic signed [OUT_W-1:0]  mac_sum;
    logic                     accept;

    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
`ifdef GNN_RELU_EN
        return v[OUT_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int n = 0; n < N; n++) begin
            for (int f = 0; f < F_IN; f++) begin
                agg[n][f] = '0;
                for (int m = 0; m < N; m++) begin
                    if (adj_r[n*N+m])
                        agg[n][f] = agg[n][f] + AGG_W'(x_r[m][f]);
                end
            end
        end
    end

    // Sign-extend both operands to accumulator width; the true product always fits.
    assign prod    = OUT_W'(a_r[n_cnt][i_cnt]) * OUT_W'(w_r[i_cnt][o_cnt]);
    assign mac_sum = ((i_cnt == '0) ? '0 : acc) + prod;

    // Operand and aggregate registers carry data only, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            adj_r <= adj;
            for (int n = 0; n < N; n++)
                for (int f = 0; f < F_IN; f++)
                    x_r[n][f] <= x_flat[(n*F_IN+f)*IN_W +: IN_W];
            for (int i = 0; i < F_IN; i++)
                for (int o = 0; o < F_OUT; o++)
                    w_r[i][o] <= w_flat[(i*F_OUT+o)*W_W +: W_W];
        end
        if (state == S_AGGR) begin
            for (int n = 0; n < N; n++)
                for (int f = 0; f < F_IN; f++)
                    a_r[n][f] <= agg[n][f];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            n_cnt     <= '0;
            o_cnt     <= '0;
            i_cnt     <= '0;
            acc       <= '0;
            for (int n = 0; n < N; n++)
                for (int o = 0; o < F_OUT; o++)
                    y_r[n][o] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state <= S_AGGR;
                        n_cnt <= '0;
                        o_cnt <= '0;
                        i_cnt <= '0;
                        for (int n = 0; n < N; n++)
                            for (int o = 0; o < F_OUT; o++)
                                y_r[n][o] <= '0;
                    end
                end
                S_AGGR: state <= S_MAC;
                S_MAC: begin
                    acc <= mac_sum;
                    if (i_cnt == I_LAST) begin
                        y_r[n_cnt][o_cnt] <= relu(mac_sum);
                        i_cnt <= '0;
                        if (o_cnt == O_LAST) begin
                            o_cnt <= '0;
                            if (n_cnt == N_LAST) begin
                                n_cnt     <= '0;
                                state     <= S_OUT;
                                out_valid <= 1'b1;
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                            end
                        end else begin
                            o_cnt <= o_cnt + OW'(1);
                        end
                    end else begin
                        i_cnt <= i_cnt + FW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar gn = 0; gn < N; gn++) begin : g_y_n
        for (genvar go = 0; go < F_OUT; go++) begin : g_y_o
            assign y_flat[(gn*F_OUT+go)*OUT_W +: OUT_W] = y_r[gn][go];
        end
    end

endmodule

// File: tb/tb_gnn_layer_seq.sv
// Directed self-checking bench for gnn_layer_seq (default sizes), either GNN_RELU_EN build.
module tb_gnn_layer_seq;

    localparam int N     = 4;
    localparam int F_IN  = 4;
    localparam int F_OUT = 2;
    localparam int IN_W  = 5;
    localparam int W_W   = 5;
    localparam int AGG_W = IN_W + $clog2(N);
    localparam int OUT_W = AGG_W + W_W + $clog2(F_IN);
    localparam int XW    = N*F_IN*IN_W;
    localparam int WW    = F_IN*F_OUT*W_W;
    localparam int YW    = N*F_OUT*OUT_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x_flat;
    logic [WW-1:0] w_flat;
    logic [N*N-1:0] adj;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] y_flat;

    gnn_layer_seq #(.N(N), .F_IN(F_IN), .F_OUT(F_OUT), .IN_W(IN_W), .W_W(W_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .w_flat(w_flat), .adj(adj),
        .out_valid(out_valid), .out_ready(out_ready), .y_flat(y_flat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [XW-1:0]   xv;
    logic [WW-1:0]   wv;
    logic [N*N-1:0]  adjv;
    int              ey [N][F_OUT];
    int              lat;
    logic [YW-1:0]   y_snap;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int relu_m(input int v);
`ifdef GNN_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic set_x_const(input int v);
        for (int k = 0; k < N*F_IN; k++) xv[k*IN_W +: IN_W] = IN_W'(v);
    endtask

    task automatic set_x_node();
        for (int m = 0; m < N; m++)
            for (int f = 0; f < F_IN; f++) xv[(m*F_IN+f)*IN_W +: IN_W] = IN_W'(m + 1);
    endtask

    task automatic set_w_const(input int v);
        for (int k = 0; k < F_IN*F_OUT; k++) wv[k*W_W +: W_W] = W_W'(v);
    endtask

    task automatic set_ey_const(input int v);
        for (int n = 0; n < N; n++)
            for (int o = 0; o < F_OUT; o++) ey[n][o] = v;
    endtask

    task automatic check_y(input string tag);
        logic [OUT_W-1:0] e;
        for (int n = 0; n < N; n++)
            for (int o = 0; o < F_OUT; o++) begin
                e = OUT_W'(relu_m(ey[n][o]));
                check($sformatf("%s_y%0d%0d", tag, n, o),
                      128'(y_flat[(n*F_OUT+o)*OUT_W +: OUT_W]), 128'(e));
            end
    endtask

    task automatic start_txn();
        @(negedge clk);
        x_flat = xv; w_flat = wv; adj = adjv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid is seen; +1 gives the
    // edge at which downstream first samples it high.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic finish_txn(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ov_drop"}, 128'(out_valid), 128'(0));
        check({tag, "_ready_back"}, 128'(in_ready), 128'(1));
        out_ready = 1'b0;
    endtask

    task automatic run_test(input string tag, input bit check_lat);
        start_txn();
        wait_valid(lat);
        if (check_lat) check({tag, "_latency"}, 128'(lat + 1), 128'(34));
        else check({tag, "_timeout"}, 128'(lat < 200), 128'(1));
        check_y(tag);
        finish_txn(tag);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x_flat = '0; w_flat = '0; adj = '0;
        xv = '0; wv = '0; adjv = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ov", 128'(out_valid), 128'(0));
        check("rst_ir", 128'(in_ready), 128'(1));
        check("rst_y", 128'(y_flat), 128'(0));
        @(negedge clk) rst_n = 1'b1;

        adjv = 16'h8421; set_x_const(1); set_w_const(1); set_ey_const(4);
        run_test("diag", 1'b1);

        adjv = 16'hFFFF; set_x_node(); set_w_const(1); set_ey_const(40);
        run_test("full", 1'b1);

        adjv = 16'h8421; set_x_const(-16); set_w_const(15); set_ey_const(-960);
        run_test("neg", 1'b0);

        adjv = 16'hFFFF; set_x_const(-16); set_w_const(-16); set_ey_const(4096);
        run_test("ext", 1'b0);

        // Node 0 sums nodes 1,2; node 3 copies node 0; nodes 1,2 have empty rows.
        adjv = 16'h1006; set_x_node();
        for (int i = 0; i < F_IN; i++) begin
            wv[(i*F_OUT+0)*W_W +: W_W] = W_W'(i + 1);
            wv[(i*F_OUT+1)*W_W +: W_W] = W_W'(-1);
        end
        set_ey_const(0);
        ey[0][0] = 50; ey[0][1] = -20; ey[3][0] = 10; ey[3][1] = -4;
        run_test("mix", 1'b0);

        // Backpressure: hold output for 10 cycles while offering new input
        adjv = 16'h8421; set_x_const(1); set_w_const(1); set_ey_const(4);
        start_txn();
        wait_valid(lat);
        check("bp_timeout", 128'(lat < 200), 128'(1));
        y_snap = y_flat;
        xv = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; x_flat = xv;
            @(posedge clk);
            #1;
            check($sformatf("bp_ir%0d", c), 128'(in_ready), 128'(0));
            check($sformatf("bp_ov%0d", c), 128'(out_valid), 128'(1));
            check($sformatf("bp_y%0d", c), 128'(y_flat), 128'(y_snap));
        end
        check_y("bp");
        @(negedge clk);
        in_valid = 1'b0;
        finish_txn("bp");

        // Reset during MAC: discard the transaction entirely
        set_x_const(1);
        start_txn();
        repeat (16) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 128'(out_valid), 128'(0));
        check("mid_rst_ir", 128'(in_ready), 128'(1));
        check("mid_rst_y", 128'(y_flat), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("mid_rst_nopulse", 128'(seen), 128'(0));
        run_test("post_rst", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
